// File: rtl/multi_cycle_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package multi_cycle_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder_4.sv
// 4-bit ripple-carry slice adder; the only adder used by the controller datapath.
module ripple_carry_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] carry_chain;

  assign carry_chain[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_full_adder
    assign s[gi]               = a[gi] ^ b[gi] ^ carry_chain[gi];
    assign carry_chain[gi + 1] = (a[gi] & b[gi]) | (carry_chain[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry_chain[4];

endmodule

// File: rtl/multi_cycle_adder_ctrl.sv
// Nibble-serial adder: latches A/B/cin on accept, adds one 4-bit slice per cycle
// LSB first, then presents the registered result under a valid/ready handshake.
module multi_cycle_adder_ctrl
  import multi_cycle_adder_pkg::*;
#(
  parameter int N_NIBBLES = 4,
  localparam int W = SLICE_W * N_NIBBLES
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_carry_in,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_s,
  output logic         o_carry_out,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int CW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_NIBBLES - 1);

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, b_reg, result_reg;
  logic [CW-1:0] cnt_reg;
  logic          carry_reg, overflow_reg;
  logic [3:0]    slice_s;
  logic          slice_cout;
  logic          last_slice;

  assign last_slice = (cnt_reg == LAST_CNT);

  ripple_carry_adder_4 u_slice_adder (
    .a    (a_reg[cnt_reg*SLICE_W +: SLICE_W]),
    .b    (b_reg[cnt_reg*SLICE_W +: SLICE_W]),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_valid)    state_next = BUSY;
      BUSY:    if (last_slice) state_next = DONE;
      DONE:    if (i_ready)    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Operands are only captured in IDLE, so input activity in BUSY/DONE is ignored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      cnt_reg      <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            a_reg     <= i_a;
            b_reg     <= i_b;
            carry_reg <= i_carry_in;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          result_reg[cnt_reg*SLICE_W +: SLICE_W] <= slice_s;
          carry_reg <= slice_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          // Top slice's sum MSB is the result sign bit.
          if (last_slice)
            overflow_reg <= (a_reg[W-1] == b_reg[W-1]) && (slice_s[3] != a_reg[W-1]);
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = (state_reg == IDLE);
  assign o_valid     = (state_reg == DONE);
  assign o_busy      = (state_reg == BUSY);
  assign o_s         = result_reg;
  assign o_carry_out = carry_reg;
  assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_multi_cycle_adder_ctrl.sv
// Directed self-checking bench for multi_cycle_adder_ctrl with N_NIBBLES=4.
module tb_multi_cycle_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a, i_b;
  logic         i_carry_in;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_s;
  logic         o_carry_out;
  logic         o_overflow;
  logic         o_busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  multi_cycle_adder_ctrl #(.N_NIBBLES(N)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_carry_in  (i_carry_in),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_s         (o_s),
    .o_carry_out (o_carry_out),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // One transaction: accept, measure latency, check result; optional 10-cycle backpressure.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] exp_s, input logic exp_c,
                       input logic exp_o, input bit hold);
    int lat;
    int bad;
    @(negedge i_clk);
    i_valid = 1'b1; i_a = a; i_b = b; i_carry_in = cin; i_ready = !hold;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_a = W'($urandom); i_b = W'($urandom); i_carry_in = ~cin;
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(N));
    check({tag, "_s"}, 32'(o_s), 32'(exp_s));
    check({tag, "_cout"}, 32'(o_carry_out), 32'(exp_c));
    check({tag, "_ovf"}, 32'(o_overflow), 32'(exp_o));
    if (hold) begin
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge i_clk);
        i_valid = 1'b1; i_a = W'($urandom); i_b = W'($urandom);
        @(posedge i_clk); #1;
        if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_s !== exp_s ||
            o_carry_out !== exp_c || o_overflow !== exp_o) bad++;
      end
      check({tag, "_hold_violations"}, 32'(bad), 32'd0);
      @(negedge i_clk);
      i_valid = 1'b0; i_ready = 1'b1;
    end
    @(posedge i_clk); #1;
    check({tag, "_back_idle_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_back_idle_valid"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    int bad;
    i_reset = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_carry_in = 1'b0; i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_s",     32'(o_s),     32'd0);
    check("rst_cout",  32'(o_carry_out), 32'd0);
    check("rst_ovf",   32'(o_overflow),  32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    do_op("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    do_op("vffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op("v7fff", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op("v8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op("v0f0f", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0);
    do_op("bp",    16'hA5A5, 16'h1111, 1'b0, 16'hB6B6, 1'b0, 1'b0, 1'b1);

    // Abort after two BUSY cycles; reset must act before any clock edge.
    @(negedge i_clk);
    i_valid = 1'b1; i_a = 16'h0F0F; i_b = 16'h0F0F; i_carry_in = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("abort_pre_busy", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    #1;
    check("abort_busy",  32'(o_busy),  32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_s",     32'(o_s),     32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk); #1;
      if (o_valid !== 1'b0) bad++;
    end
    check("abort_no_valid", 32'(bad), 32'd0);
    do_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_cycle_adder_ctrl.md
MULTI_CYCLE_ADDER_CTRL -- requirements
Module: multi_cycle_adder_ctrl

Interface
REQ-001 Parameter N_NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*N_NIBBLES; legal range 2..8.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  request valid; operands and carry-in are presented.
REQ-005 o_ready  output  1  controller can accept a request this cycle.
REQ-006 i_a  input  W  operand A, sampled on accept.
REQ-007 i_b  input  W  operand B, sampled on accept.
REQ-008 i_carry_in  input  1  carry into bit 0, sampled on accept.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  consumer accepts the result.
REQ-011 o_s  output  W  sum A+B+carry_in, modulo 2^W.
REQ-012 o_carry_out  output  1  unsigned carry out of bit W-1.
REQ-013 o_overflow  output  1  two's-complement overflow of the W-bit sum.
REQ-014 o_busy  output  1  high while the FSM is in BUSY.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-016 IDLE: o_ready=1, o_valid=0; accept when i_valid&&o_ready: latch i_a, i_b, i_carry_in; clear nibble counter; go BUSY.
REQ-017 BUSY: each cycle, one 4-bit add of nibble k of A and B plus the carry register; sum nibble written to result bits [4k+3:4k]; carry register takes the slice carry out; counter increments.
REQ-018 Nibble order SHALL be LSB first; the first BUSY cycle uses the latched i_carry_in as slice carry.
REQ-019 After the BUSY cycle with counter = N_NIBBLES-1, go DONE; BUSY lasts exactly N_NIBBLES cycles.
REQ-020 Latency: accept at edge t -> o_valid=1 from edge t+N_NIBBLES.
REQ-021 DONE: o_valid=1, o_ready=0; o_s, o_carry_out and o_overflow held stable until i_ready=1.
REQ-022 On o_valid&&i_ready go IDLE; the earliest next accept is the following cycle (max throughput one result per N_NIBBLES+2 cycles).
REQ-023 o_carry_out = carry register after the final slice.
REQ-024 o_overflow = (A[W-1]==B[W-1]) && (o_s[W-1]!=A[W-1]).
REQ-025 i_valid SHALL be ignored in BUSY and DONE; input changes after accept SHALL NOT affect the result.
REQ-026 o_s, o_carry_out and o_overflow are don't-care outside DONE; they hold the last result in IDLE.
REQ-027 All outputs SHALL be driven from registers or FSM state only, with no combinational path from inputs.

Reset
REQ-028 i_reset=1 SHALL immediately force IDLE, o_ready=1, o_valid=0, o_busy=0, o_s=0, o_carry_out=0, o_overflow=0, and clear counter, carry and operand registers.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation with no result delivered.

Structure
REQ-030 Shared package multi_cycle_adder_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the slice-width constant 4.
REQ-031 Datapath SHALL instantiate exactly one ripple_carry_adder_4 as the slice adder; no other adder in the module.

Verification
REQ-032 N_NIBBLES=4: A=0x1234, B=0x4321, cin=0 -> o_s=0x5555, cout=0, ovf=0, o_valid exactly 4 cycles after accept.
REQ-033 A=0xFFFF, B=0x0001, cin=0 -> o_s=0x0000, cout=1, ovf=0 (carry ripples through all slices).
REQ-034 A=0x7FFF, B=0x0000, cin=1 -> o_s=0x8000, cout=0, ovf=1.
REQ-035 Backpressure: i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0, new i_valid pulses ignored; i_ready=1 -> IDLE next cycle.
REQ-036 Reset after 2 BUSY cycles -> o_busy=0, o_ready=1 without waiting for an edge; no o_valid; next request 0x0001+0x0001 -> 0x0002.
